// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between two requesters. Requester 0 is the multicycle core
//   (fetch/load/store) and requester 1 is the debug/program loader. Accesses are serialized
//   by a small FSM (IDLE -> ISSUE -> [WAIT] -> DONE). The winner's command is captured when
//   it is accepted. Loads wait READ_LATENCY cycles for memory data. The owner receives a
//   one-cycle done pulse together with its read data.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   m0_* / m1_*             requester command inputs (req, we, addr, wdata, funct3)
//                           and completion outputs (done, rdata)
//   mem_write, mem_funct3,  memory command driven from the captured registers
//   mem_write_address,
//   mem_write_data,
//   mem_read_address
//   mem_read_data           memory load data, valid READ_LATENCY cycles after the address
//   busy                    high in every state except IDLE
//   owner                   requester of the current or most recent transaction
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ARB_MODE     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              owner
);

  localparam logic [2:0] LatCnt = 3'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        funct3_q;
  logic [2:0]        cnt_q;
  logic              grant1;
  logic              accept;

  assign accept = (state_q == StIdle) && (m0_req || m1_req);

  // grant1 = 1 selects m1. In round-robin mode a tie goes to whoever was not served last.
  always_comb begin
    grant1 = 1'b0;
    if (ARB_MODE == 0) begin
      grant1 = !m0_req && m1_req;
    end else begin
      grant1 = m1_req && (!m0_req || !last_owner_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (m0_req || m1_req) state_d = StIssue;
      StIssue: state_d = we_q ? StDone : StWait;
      StWait:  if (cnt_q == LatCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      funct3_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= grant1;
        we_q     <= grant1 ? m1_we     : m0_we;
        addr_q   <= grant1 ? m1_addr   : m0_addr;
        wdata_q  <= grant1 ? m1_wdata  : m0_wdata;
        funct3_q <= grant1 ? m1_funct3 : m0_funct3;
      end
      if (state_q == StIssue) begin
        cnt_q <= 3'd1;
      end
      if (state_q == StWait) begin
        if (cnt_q == LatCnt) begin
          rdata_q <= mem_read_data;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
      if (state_q == StDone) begin
        last_owner_q <= owner_q;
      end
    end
  end

  always_comb begin
    mem_write         = (state_q == StIssue) && we_q;
    mem_funct3        = funct3_q;
    mem_write_address = addr_q;
    mem_write_data    = wdata_q;
    mem_read_address  = addr_q;
    busy              = (state_q != StIdle);
    owner             = owner_q;
    m0_done           = (state_q == StDone) && !owner_q;
    m1_done           = (state_q == StDone) && owner_q;
    // Stores return zero data; read data is only visible alongside done.
    m0_rdata          = (m0_done && !we_q) ? rdata_q : '0;
    m1_rdata          = (m1_done && !we_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a: READ_LATENCY=1, round-robin.
// Instance b: READ_LATENCY=3, fixed priority. Each instance has a behavioural memory
// whose read pipeline depth matches its latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [2:0]  a_m0_funct3, a_m1_funct3;
  logic        a_m0_done, a_m1_done, a_mem_write, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_write_address, a_mem_write_data;
  logic [31:0] a_mem_read_address, a_mem_read_data;
  logic [2:0]  a_mem_funct3;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [2:0]  b_m0_funct3, b_m1_funct3;
  logic        b_m0_done, b_m1_done, b_mem_write, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_write_address, b_mem_write_data;
  logic [31:0] b_mem_read_address, b_mem_read_data;
  logic [2:0]  b_mem_funct3;
  logic [31:0] b_p1, b_p2;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'hDEADBEEF : {16'hCAFE, addr[15:0]};
  endfunction

  always @(posedge clk) begin
    a_mem_read_data <= mem_model(a_mem_read_address);
    b_p1            <= mem_model(b_mem_read_address);
    b_p2            <= b_p1;
    b_mem_read_data <= b_p2;
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .ARB_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_funct3(a_m0_funct3), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_funct3(a_m1_funct3), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
    .mem_write(a_mem_write), .mem_funct3(a_mem_funct3),
    .mem_write_address(a_mem_write_address), .mem_write_data(a_mem_write_data),
    .mem_read_address(a_mem_read_address), .mem_read_data(a_mem_read_data),
    .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_funct3(b_m0_funct3), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_funct3(b_m1_funct3), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
    .mem_write(b_mem_write), .mem_funct3(b_mem_funct3),
    .mem_write_address(b_mem_write_address), .mem_write_data(b_mem_write_data),
    .mem_read_address(b_mem_read_address), .mem_read_data(b_mem_read_data),
    .busy(b_busy), .owner(b_owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    rst_n = 1'b0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0; a_m0_funct3 = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0; a_m1_funct3 = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0; b_m0_funct3 = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0; b_m1_funct3 = 0;
    step(2);
    check("rst_busy", a_busy, 0);
    check("rst_mem_write", a_mem_write, 0);
    check("rst_rd_addr", a_mem_read_address, 0);
    check("rst_owner", a_owner, 0);
    check("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;
    step();

    // Test 1: m0 load of 0x10, latency 1 -> done at cycle 3.
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10; a_m0_funct3 = 3'd2;
    check("t1_c0_busy", a_busy, 0);
    step();
    check("t1_c1_busy", a_busy, 1);
    check("t1_c1_rd_addr", a_mem_read_address, 32'h10);
    check("t1_c1_mem_write", a_mem_write, 0);
    check("t1_c1_funct3", a_mem_funct3, 2);
    step();
    check("t1_c2_done", a_m0_done, 0);
    step();
    check("t1_c3_done", a_m0_done, 1);
    check("t1_c3_rdata", a_m0_rdata, 32'hDEADBEEF);
    check("t1_c3_m1_done", a_m1_done, 0);
    a_m0_req = 0;
    step();
    check("t1_c4_done", a_m0_done, 0);
    check("t1_c4_rdata", a_m0_rdata, 0);
    check("t1_c4_busy", a_busy, 0);

    // Test 2: m1 store, write strobe only in cycle 1, done at cycle 2.
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678; a_m1_funct3 = 3'd2;
    check("t2_c0_mem_write", a_mem_write, 0);
    step();
    check("t2_c1_mem_write", a_mem_write, 1);
    check("t2_c1_wr_addr", a_mem_write_address, 32'h20);
    check("t2_c1_wr_data", a_mem_write_data, 32'h12345678);
    check("t2_c1_funct3", a_mem_funct3, 2);
    check("t2_c1_owner", a_owner, 1);
    check("t2_c1_done", a_m1_done, 0);
    step();
    check("t2_c2_mem_write", a_mem_write, 0);
    check("t2_c2_done", a_m1_done, 1);
    check("t2_c2_rdata", a_m1_rdata, 0);
    check("t2_c2_m0_done", a_m0_done, 0);
    a_m1_req = 0;
    step();
    check("t2_c3_busy", a_busy, 0);
    check("t2_c3_wr_addr_hold", a_mem_write_address, 32'h20);

    // Test 3: round-robin with both requesters held -> m0, m1, m0, m1.
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h40;
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h44; a_m1_wdata = 32'h55;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      step();
      if (a_m0_done || a_m1_done) begin
        check("t3_rr_owner", {31'b0, a_m1_done}, {31'b0, got[0]});
        check("t3_rr_both", {31'b0, a_m0_done & a_m1_done}, 0);
        if (a_m0_done) check("t3_rr_rdata", a_m0_rdata, 32'hCAFE0040);
        got++;
      end
    end
    check("t3_rr_count", 32'(got), 4);
    a_m0_req = 0; a_m1_req = 0;
    step(2);

    // Test 5: reset during WAIT of a load abandons it.
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
    step(2);
    check("t5_wait_busy", a_busy, 1);
    rst_n = 0;
    #1;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_rd_addr", a_mem_read_address, 0);
    check("t5_rst_done", a_m0_done, 0);
    a_m0_req = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_done", {31'b0, a_m0_done | a_m1_done}, 0);
    end
    // Reset in ISSUE of a store drops the strobe at once.
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h30;
    step();
    check("t5_issue_write", a_mem_write, 1);
    rst_n = 0;
    #1;
    check("t5_rst_write", a_mem_write, 0);
    a_m1_req = 0;
    step();
    rst_n = 1;
    step();
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h40;
    step(2);
    check("t5_after_c2_done", a_m0_done, 0);
    step();
    check("t5_after_done", a_m0_done, 1);
    check("t5_after_rdata", a_m0_rdata, 32'hCAFE0040);
    a_m0_req = 0;
    step(2);

    // Test 4: fixed priority, both held -> m0 three times, then m1 once m0 lets go.
    b_m0_req = 1; b_m0_we = 1; b_m0_addr = 32'h80; b_m0_wdata = 32'h1;
    b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h84; b_m1_wdata = 32'h2;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      step();
      if (b_m0_done || b_m1_done) begin
        check("t4_fp_owner", {31'b0, b_m1_done}, (got < 3) ? 32'd0 : 32'd1);
        got++;
        if (got == 3) b_m0_req = 0;
      end
    end
    check("t4_fp_count", 32'(got), 4);
    b_m1_req = 0;
    step(2);

    // Test 6: latency 3, m0 drops req and changes address after acceptance.
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h10;
    step();
    b_m0_req = 0; b_m0_addr = 32'h99;
    check("t6_c1_rd_addr", b_mem_read_address, 32'h10);
    step(3);
    check("t6_c4_done", b_m0_done, 0);
    step();
    check("t6_c5_done", b_m0_done, 1);
    check("t6_c5_rdata", b_m0_rdata, 32'hDEADBEEF);
    step();
    check("t6_c6_done", b_m0_done, 0);
    check("t6_c6_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
